// File: rtl/dir_sel_pkg.sv
// Shared constants for the direction-select front end: direction codes,
// sequencer state encodings and a width helper for counters.
package dir_sel_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dir_debounce.sv
// One button channel: two-flop synchroniser, mismatch counter and a
// registered single-cycle press strobe on each accepted 0->1 level change.
module dir_debounce
    import dir_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        // Any cycle where the synced level agrees with stable restarts the count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                press_d  = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/dir_select_sequencer.sv
// Debounces four direction buttons and latches the winning press as the
// mux select code. Optional idle auto-scan is enabled by DIR_SEL_AUTO_SCAN_EN.
module dir_select_sequencer
    import dir_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_CYCLES     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_left,
    output logic select1,
    output logic select0,
    output logic sel_valid,
    output logic sel_changed
);

    logic [3:0] btn_raw;
    logic [3:0] btn_stable;
    logic [3:0] btn_press;

    // Bit index equals the direction code, so the lowest set bit wins.
    assign btn_raw = {btn_left, btn_down, btn_right, btn_up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            dir_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (clk),
                .rst_n  (rst_n),
                .raw    (btn_raw[gi]),
                .stable (btn_stable[gi]),
                .press  (btn_press[gi])
            );
        end
    endgenerate

    logic       press_any;
    logic [1:0] press_code;

    always_comb begin
        press_any  = |btn_press;
        press_code = DIR_UP;
        for (int i = 3; i >= 0; i--) begin
            if (btn_press[i]) begin
                press_code = 2'(i);
            end
        end
    end

    logic scan_step;

`ifdef DIR_SEL_AUTO_SCAN_EN
    localparam int SW = clog2(SCAN_CYCLES);
    localparam logic [SW-1:0] IDLE_LAST = SW'(SCAN_CYCLES - 1);

    logic [SW-1:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        scan_step  = (btn_stable == 4'b0000) && (idle_cnt_q == IDLE_LAST);
        idle_cnt_d = idle_cnt_q + 1'b1;
        if ((btn_stable != 4'b0000) || scan_step) begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_scan;
    assign scan_step   = 1'b0;
    assign unused_scan = ^{btn_stable, SCAN_CYCLES};
`endif

    state_t     state_q, state_d;
    logic [1:0] select_q, select_d;
    logic       valid_q, valid_d;
    logic       changed_q, changed_d;

    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        if (press_any) begin
            state_d   = ST_HOLD;
            select_d  = press_code;
            valid_d   = 1'b1;
            // Leaving IDLE always counts as a change, even onto code 00.
            changed_d = (state_q == ST_IDLE) || (press_code != select_q);
        end else if (scan_step) begin
            state_d   = ST_SCAN;
            select_d  = select_q + 2'd1;
            valid_d   = 1'b1;
            changed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            select_q  <= DIR_UP;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign select1     = select_q[1];
    assign select0     = select_q[0];
    assign sel_valid   = valid_q;
    assign sel_changed = changed_q;

endmodule

// File: tb/tb_dir_select_sequencer.sv
// Randomised bench for dir_select_sequencer: a cycle-level reference model
// predicts select pulses into a queue that a monitor drains and compares.
module tb_dir_select_sequencer;
    import dir_sel_pkg::*;

    localparam int DEB  = 16;
    localparam int SCAN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic select1, select0, sel_valid, sel_changed;

    dir_select_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .SCAN_CYCLES    (SCAN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .select1    (select1),
        .select0    (select0),
        .sel_valid  (sel_valid),
        .sel_changed(sel_changed)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         edge_no;
        logic [1:0] code;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: a level is accepted after DEB consecutive sampled
    // cycles disagreeing with it; the sample seen is the input two edges back.
    logic [3:0] m_stable = '0, m_p1 = '0, m_p2 = '0, m_press = '0;
    int         m_run[4] = '{0, 0, 0, 0};
    logic [1:0] m_sel = 2'b00;
    logic       m_valid = 1'b0;
    int         m_idle = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] raw;
        int         win;
        logic [1:0] nxt;
        exp_t       e;
        if (!rst_n) begin
            m_stable = '0; m_p1 = '0; m_p2 = '0; m_press = '0;
            for (int b = 0; b < 4; b++) m_run[b] = 0;
            m_sel = 2'b00; m_valid = 1'b0; m_idle = 0;
            exp_q.delete();
        end else begin
            raw = {btn_left, btn_down, btn_right, btn_up};
            win = -1;
            for (int i = 3; i >= 0; i--) if (m_press[i]) win = i;
            if (win >= 0) begin
                nxt = 2'(win);
                if (!m_valid || nxt != m_sel) begin
                    e.edge_no = cyc + 1; e.code = nxt; exp_q.push_back(e);
                end
                m_sel = nxt; m_valid = 1'b1;
            end
`ifdef DIR_SEL_AUTO_SCAN_EN
            if (m_stable != 4'b0000) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == SCAN) begin
                    m_idle = 0;
                    m_sel = m_sel + 2'd1; m_valid = 1'b1;
                    e.edge_no = cyc + 1; e.code = m_sel; exp_q.push_back(e);
                end
            end
`endif
            m_press = '0;
            for (int b = 0; b < 4; b++) begin
                if (m_p2[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_stable[b] = ~m_stable[b];
                        m_run[b] = 0;
                        m_press[b] = m_stable[b];
                    end
                end else m_run[b] = 0;
            end
            m_p2 = m_p1;
            m_p1 = raw;
        end
    end

    int pulses = 0;
    int last_pulse = -1;

    always @(negedge clk) begin : mon
        exp_t e;
        #1;
        checks++;
        if ({select1, select0} !== m_sel || sel_valid !== m_valid) begin
            errors++;
            $display("FAIL level cyc=%0d: got sel=%b valid=%b, expected sel=%b valid=%b",
                     cyc, {select1, select0}, sel_valid, m_sel, m_valid);
        end
        if (sel_changed === 1'b1) begin
            pulses++;
            last_pulse = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_pulse cyc=%0d: got pulse with sel=%b, expected none",
                         cyc, {select1, select0});
            end else begin
                e = exp_q.pop_front();
                if (e.edge_no != cyc || e.code !== {select1, select0}) begin
                    errors++;
                    $display("FAIL pulse: got edge %0d sel=%b, expected edge %0d sel=%b",
                             cyc, {select1, select0}, e.edge_no, e.code);
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: got no pulse, expected one at edge %0d sel=%b",
                     e.edge_no, e.code);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
        else $display("check %s: %0d", name, got);
    endtask

    task automatic drive(input logic [3:0] b);
        @(negedge clk);
        {btn_left, btn_down, btn_right, btn_up} = b;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int p0;
    int t0;

    initial begin
        // Reset held with buttons toggling.
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) drive(4'($urandom));
        drive(4'b0000);
        rst_n = 1'b1;
        wait_cyc(3);
        chk("reset_sel", int'({select1, select0}), int'(DIR_UP));
        chk("reset_valid", int'(sel_valid), 0);

        // Right held 40 cycles: one pulse at edge 18.
        p0 = pulses;
        drive(4'b0010);
        t0 = cyc + 1;
        wait_cyc(40);
`ifndef DIR_SEL_AUTO_SCAN_EN
        chk("right_sel", int'({select1, select0}), int'(DIR_RIGHT));
        chk("right_valid", int'(sel_valid), 1);
        chk("right_pulses", pulses - p0, 1);
        chk("right_latency", last_pulse, t0 + 18);
`endif
        drive(4'b0000);
        wait_cyc(25);

        // Down glitch then real press.
        p0 = pulses;
        drive(4'b0100);
        wait_cyc(10);
        drive(4'b0000);
        wait_cyc(20);
`ifndef DIR_SEL_AUTO_SCAN_EN
        chk("glitch_sel", int'({select1, select0}), int'(DIR_RIGHT));
        chk("glitch_pulses", pulses - p0, 0);
`endif
        drive(4'b0100);
        wait_cyc(20);
`ifndef DIR_SEL_AUTO_SCAN_EN
        chk("down_sel", int'({select1, select0}), int'(DIR_DOWN));
        chk("down_pulses", pulses - p0, 1);
`endif
        drive(4'b0000);
        wait_cyc(25);

        // Up and left together: up wins, left held gives nothing more.
        p0 = pulses;
        drive(4'b1001);
        wait_cyc(25);
        chk("tie_sel", int'({select1, select0}), int'(DIR_UP));
        drive(4'b1000);
        wait_cyc(30);
`ifndef DIR_SEL_AUTO_SCAN_EN
        chk("tie_hold_sel", int'({select1, select0}), int'(DIR_UP));
        chk("tie_pulses", pulses - p0, 1);
`endif
        drive(4'b0000);
        wait_cyc(25);

        // Repeat press of the held direction, then reset mid-debounce.
        drive(4'b0100);
        wait_cyc(25);
        drive(4'b0000);
        wait_cyc(25);
        p0 = pulses;
        drive(4'b0100);
        wait_cyc(25);
`ifndef DIR_SEL_AUTO_SCAN_EN
        chk("repeat_pulses", pulses - p0, 0);
        chk("repeat_sel", int'({select1, select0}), int'(DIR_DOWN));
`endif
        drive(4'b0000);
        wait_cyc(25);
        drive(4'b0010);
        wait_cyc(10);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", int'({select1, select0}), int'(DIR_UP));
        chk("async_rst_valid", int'(sel_valid), 0);
        chk("async_rst_changed", int'(sel_changed), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(30);
        chk("after_rst_sel", int'({select1, select0}), int'(DIR_RIGHT));
        drive(4'b0000);
        wait_cyc(25);

        // Hold at left, release everything.
        drive(4'b1000);
        wait_cyc(25);
        chk("left_sel", int'({select1, select0}), int'(DIR_LEFT));
        drive(4'b0000);
`ifdef DIR_SEL_AUTO_SCAN_EN
        wait_cyc(26);
        chk("scan_wrap_sel", int'({select1, select0}), int'(DIR_UP));
        wait_cyc(8);
        chk("scan_step_sel", int'({select1, select0}), int'(DIR_RIGHT));
`else
        p0 = pulses;
        wait_cyc(60);
        chk("no_scan_sel", int'({select1, select0}), int'(DIR_LEFT));
        chk("no_scan_pulses", pulses - p0, 0);
`endif
        drive(4'b0100);
        wait_cyc(25);
        chk("scan_exit_sel", int'({select1, select0}), int'(DIR_DOWN));
        drive(4'b0000);
        wait_cyc(25);

        // Random button patterns with occasional resets.
        for (int it = 0; it < 150; it++) begin
            drive(4'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                wait_cyc(2);
                rst_n = 1'b1;
            end
            wait_cyc($urandom_range(1, 40));
        end

        drive(4'b0000);
        wait_cyc(40);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
